// File: rtl/alu_decode_stage.sv
// RV32I decode stage for alu_top: decodes OP, OP-IMM and LUI words into an ALU
// op code, register indices and immediate, held in a one-entry output register.
module alu_decode_stage #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            inst_ready_o,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [OP_W-1:0] alu_op_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic            use_imm_o,
    output logic            illegal_o,
    output logic [31:0]     dec_count_o
);

    typedef enum logic [OP_W-1:0] {
        OP_ADD = OP_W'(0),
        OP_SUB = OP_W'(1),
        OP_XOR = OP_W'(2),
        OP_OR  = OP_W'(3),
        OP_AND = OP_W'(4),
        OP_SLL = OP_W'(5),
        OP_SRL = OP_W'(6),
        OP_SRA = OP_W'(7),
        OP_SLT = OP_W'(8)
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_OP  = 7'b0110011,
        OPC_IMM = 7'b0010011,
        OPC_LUI = 7'b0110111
    } opcode_e;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [2:0] funct3;
    logic [6:0] funct7;

    alu_op_e         op_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] imm_d;
    logic            use_imm_d, ill_d;

    alu_op_e         op_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] imm_q;
    logic            use_imm_q, ill_q;
    logic            valid_q, valid_d;
    logic [31:0]     count_q, count_d;

    logic accept, take;

    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        op_d      = OP_ADD;
        rs1_d     = inst_i[19:15];
        rs2_d     = inst_i[24:20];
        rd_d      = inst_i[11:7];
        imm_d     = '0;
        use_imm_d = 1'b0;
        ill_d     = 1'b0;

        // opcode compare covers inst[1:0]; any non-11 encoding falls to default
        case (inst_i[6:0])
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)     op_d = OP_ADD;
                        else if (funct7 == F7_ALT) op_d = OP_SUB;
                        else                       ill_d = 1'b1;
                    end
                    3'b001: begin op_d = OP_SLL; ill_d = (funct7 != F7_ZERO); end
                    3'b010: begin op_d = OP_SLT; ill_d = (funct7 != F7_ZERO); end
                    3'b100: begin op_d = OP_XOR; ill_d = (funct7 != F7_ZERO); end
                    3'b110: begin op_d = OP_OR;  ill_d = (funct7 != F7_ZERO); end
                    3'b111: begin op_d = OP_AND; ill_d = (funct7 != F7_ZERO); end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     op_d = OP_SRL;
                        else if (funct7 == F7_ALT) op_d = OP_SRA;
                        else                       ill_d = 1'b1;
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            OPC_IMM: begin
                use_imm_d = 1'b1;
                rs2_d     = '0;
                imm_d     = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
                case (funct3)
                    3'b000: op_d = OP_ADD;
                    3'b010: op_d = OP_SLT;
                    3'b100: op_d = OP_XOR;
                    3'b110: op_d = OP_OR;
                    3'b111: op_d = OP_AND;
                    3'b001: begin
                        op_d  = OP_SLL;
                        imm_d = {{(XLEN-5){1'b0}}, inst_i[24:20]};
                        ill_d = (funct7 != F7_ZERO);
                    end
                    3'b101: begin
                        imm_d = {{(XLEN-5){1'b0}}, inst_i[24:20]};
                        if (funct7 == F7_ZERO)     op_d = OP_SRL;
                        else if (funct7 == F7_ALT) op_d = OP_SRA;
                        else                       ill_d = 1'b1;
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            OPC_LUI: begin
                rs1_d     = '0;
                rs2_d     = '0;
                use_imm_d = 1'b1;
                imm_d     = {inst_i[31:12], {(XLEN-20){1'b0}}};
            end
            default: ill_d = 1'b1;
        endcase

        if (ill_d) begin
            op_d      = OP_ADD;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            imm_d     = '0;
            use_imm_d = 1'b0;
        end
    end

    assign inst_ready_o = !valid_q || dec_ready_i;
    assign accept       = inst_valid_i && inst_ready_o;
    assign take         = valid_q && dec_ready_i;

    always_comb begin
        valid_d = valid_q;
        if (accept)    valid_d = 1'b1;
        else if (take) valid_d = 1'b0;
        count_d = take ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            count_q   <= '0;
            op_q      <= OP_ADD;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            // fields only change on accept so a taken bundle keeps its last values
            if (accept) begin
                op_q      <= op_d;
                rs1_q     <= rs1_d;
                rs2_q     <= rs2_d;
                rd_q      <= rd_d;
                imm_q     <= imm_d;
                use_imm_q <= use_imm_d;
                ill_q     <= ill_d;
            end
        end
    end

    assign dec_valid_o = valid_q;
    assign alu_op_o    = op_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign rd_o        = rd_q;
    assign imm_o       = imm_q;
    assign use_imm_o   = use_imm_q;
    assign illegal_o   = ill_q;
    assign dec_count_o = count_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: decode model + scoreboard and
// directed vectors with hand-computed expectations.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_ready;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [3:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        use_imm, illegal;
    logic [31:0] dec_count;

    int errors = 0;
    int checks = 0;

    alu_decode_stage #(.XLEN(32), .OP_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_valid_i(inst_valid), .inst_i(inst), .inst_ready_o(inst_ready),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .alu_op_o(alu_op), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .imm_o(imm), .use_imm_o(use_imm), .illegal_o(illegal),
        .dec_count_o(dec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        use_imm, ill;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [31:0] exp_count = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Model: pick the mnemonic from the instruction fields, then map it to its code.
    function automatic bundle_t model(input logic [31:0] w);
        bundle_t b;
        string   mn;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        int signed  simm = int'($signed(w[31:20]));
        mn = "";
        b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
        b.imm = 0; b.use_imm = 0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00)
                mn = (f3 == 0) ? "add" : (f3 == 1) ? "sll" : (f3 == 2) ? "slt" :
                     (f3 == 4) ? "xor" : (f3 == 5) ? "srl" : (f3 == 6) ? "or" :
                     (f3 == 7) ? "and" : "";
            else if (f7 == 7'h20)
                mn = (f3 == 0) ? "sub" : (f3 == 5) ? "sra" : "";
        end else if (opc == 7'h13) begin
            b.use_imm = 1; b.rs2 = 0;
            b.imm = 32'(simm);
            case (f3)
                0: mn = "add";
                2: mn = "slt";
                4: mn = "xor";
                6: mn = "or";
                7: mn = "and";
                1: mn = (f7 == 0) ? "sll" : "";
                5: mn = (f7 == 0) ? "srl" : (f7 == 7'h20) ? "sra" : "";
                default: mn = "";
            endcase
            if (f3 == 1 || f3 == 5) b.imm = 32'(w[24:20]);
        end else if (opc == 7'h37) begin
            mn = "add"; b.rs1 = 0; b.rs2 = 0; b.use_imm = 1;
            b.imm = w & 32'hFFFF_F000;
        end
        b.ill = (mn == "");
        case (mn)
            "sub": b.op = 1;  "xor": b.op = 2;  "or":  b.op = 3;
            "and": b.op = 4;  "sll": b.op = 5;  "srl": b.op = 6;
            "sra": b.op = 7;  "slt": b.op = 8;  default: b.op = 0;
        endcase
        if (b.ill) begin b.rd = 0; b.use_imm = 0; end
        return b;
    endfunction

    // Scoreboard bookkeeping from pre-edge handshake values
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_count = '0;
        end else begin
            chk("inst_ready", {31'd0, inst_ready}, {31'd0, (exp_q.size() == 0) || dec_ready});
            if (exp_q.size() != 0 && dec_ready) begin
                void'(exp_q.pop_front());
                exp_count = exp_count + 1;
            end
            if (inst_valid && inst_ready) exp_q.push_back(model(inst));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_q.size() != 0});
            chk("dec_count", dec_count, exp_count);
            if (dec_valid && exp_q.size() != 0) begin
                chk("illegal", {31'd0, illegal}, {31'd0, exp_q[0].ill});
                chk("alu_op",  {28'd0, alu_op},  {28'd0, exp_q[0].op});
                chk("rd",      {27'd0, rd},      {27'd0, exp_q[0].rd});
                chk("use_imm", {31'd0, use_imm}, {31'd0, exp_q[0].use_imm});
                if (!exp_q[0].ill) begin
                    chk("rs1", {27'd0, rs1}, {27'd0, exp_q[0].rs1});
                    if (exp_q[0].use_imm) begin
                        chk("rs2_imm", {27'd0, rs2}, 32'd0);
                        chk("imm", imm, exp_q[0].imm);
                    end else begin
                        chk("rs2", {27'd0, rs2}, {27'd0, exp_q[0].rs2});
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        inst_valid = 1'b1;
        inst       = w;
        dec_ready  = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    logic [31:0] stream [4] = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h4030D093};

    initial begin
        #1;
        chk("rst_valid",  {31'd0, dec_valid}, 32'd0);
        chk("rst_count",  dec_count, 32'd0);
        chk("rst_op",     {28'd0, alu_op}, 32'd0);
        chk("rst_imm",    imm, 32'd0);
        chk("rst_fields", {17'd0, rs1, rs2, rd}, 32'd0);
        chk("rst_flags",  {30'd0, use_imm, illegal}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(32'h002081B3);
        chk("add_valid", {31'd0, dec_valid}, 32'd1);
        chk("add_op",  {28'd0, alu_op}, 32'd0);
        chk("add_rs1", {27'd0, rs1}, 32'd1);
        chk("add_rs2", {27'd0, rs2}, 32'd2);
        chk("add_rd",  {27'd0, rd}, 32'd3);
        chk("add_flags", {30'd0, use_imm, illegal}, 32'd0);

        issue(32'h402081B3);
        chk("sub_op", {28'd0, alu_op}, 32'd1);

        issue(32'hFFF00293);
        chk("addi_op",  {28'd0, alu_op}, 32'd0);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_rd",  {27'd0, rd}, 32'd5);
        chk("addi_use", {31'd0, use_imm}, 32'd1);

        issue(32'h4030D093);
        chk("srai_op",  {28'd0, alu_op}, 32'd7);
        chk("srai_imm", imm, 32'd3);
        chk("srai_rd",  {27'd0, rd}, 32'd1);

        issue(32'h123453B7);
        chk("lui_op",  {28'd0, alu_op}, 32'd0);
        chk("lui_rs1", {27'd0, rs1}, 32'd0);
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_rd",  {27'd0, rd}, 32'd7);

        issue(32'h0030B0B3);
        chk("sltu_ill", {31'd0, illegal}, 32'd1);
        chk("sltu_op",  {28'd0, alu_op}, 32'd0);
        chk("sltu_rd",  {27'd0, rd}, 32'd0);

        issue(32'h0000006F);
        chk("jal_ill", {31'd0, illegal}, 32'd1);
        chk("jal_rd",  {27'd0, rd}, 32'd0);
        @(negedge clk);
        chk("count7", dec_count, 32'd7);

        // Stream with a three-cycle downstream stall
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int idx = 0;
            int cyc = 0;
            logic acc;
            while (idx < 4 && cyc < 50) begin
                @(negedge clk);
                inst_valid = 1'b1;
                inst       = stream[idx];
                dec_ready  = !(cyc >= 2 && cyc <= 4);
                #1;
                if (!dec_ready && dec_valid) chk("stall_ready", {31'd0, inst_ready}, 32'd0);
                acc = inst_valid && inst_ready;
                @(posedge clk);
                if (acc) idx++;
                cyc++;
            end
            if (idx < 4) chk("stream_timeout", idx, 4);
        end
        @(negedge clk);
        inst_valid = 1'b0;
        dec_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("stream_count", dec_count, 32'd4);

        // Reset while a bundle is held
        inst_valid = 1'b1;
        inst       = 32'h123453B7;
        dec_ready  = 1'b0;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("held_valid", {31'd0, dec_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, dec_valid}, 32'd0);
        chk("async_count", dec_count, 32'd0);
        chk("async_ready", {31'd0, inst_ready}, 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        dec_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
